// File: rtl/mmio_stream_bridge.sv
// mmio_stream_bridge: MMIO slave bridging register accesses to a pair of
// valid/ready streams through a TX FIFO (register writes -> m_* stream) and an
// RX FIFO (s_* stream -> register reads).
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   wr_en_i/wr_addr_i/wr_data_i/      register write port (addr[3:2] decoded)
//   wr_byteen_i
//   rd_en_i/rd_addr_i/rd_data_o       register read port, 1-cycle latency
//   m_data_o/m_valid_o/m_ready_i      outbound stream (TX FIFO head)
//   s_data_i/s_valid_i/s_ready_o      inbound stream (into RX FIFO)
//   irq_o                             RX data-available interrupt
//
// Register map (word index): 0 TXDATA (WO), 1 RXDATA (RO, pops),
// 2 STATUS (RO), 3 CTRL (flush/clr_err pulses, rx_irq_en).
module mmio_stream_bridge #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [A_WIDTH-1:0]   wr_addr_i,
    input  logic [D_WIDTH-1:0]   wr_data_i,
    input  logic [D_WIDTH/8-1:0] wr_byteen_i,
    input  logic                 rd_en_i,
    input  logic [A_WIDTH-1:0]   rd_addr_i,
    output logic [D_WIDTH-1:0]   rd_data_o,
    output logic [D_WIDTH-1:0]   m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    input  logic [D_WIDTH-1:0]   s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic                 irq_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = PW - 1;
    localparam int unsigned BW = D_WIDTH / 8;

    logic [D_WIDTH-1:0] tx_mem [DEPTH];
    logic [D_WIDTH-1:0] rx_mem [DEPTH];

    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [PW-1:0] tx_wp_n, tx_rp_n, rx_wp_n, rx_rp_n;
    logic [PW-1:0] tx_count, rx_count;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_ovf, rx_udf, rx_irq_en;
    logic          tx_ovf_n, rx_udf_n, rx_irq_en_n;

    logic [1:0]         wr_idx, rd_idx;
    logic [D_WIDTH-1:0] wdata_masked;
    logic [D_WIDTH-1:0] status;
    logic [D_WIDTH-1:0] rd_mux;
    logic               tx_wr, tx_push, tx_pop, tx_ovf_set;
    logic               rx_rd, rx_push, rx_pop, rx_udf_set;
    logic               ctrl_wr, tx_flush, rx_flush, clr_err;

    // Address bits outside [3:2] are decoded by the upstream multiplexor.
    logic unused_ok;
    assign unused_ok = ^{wr_addr_i[A_WIDTH-1:4], wr_addr_i[1:0],
                         rd_addr_i[A_WIDTH-1:4], rd_addr_i[1:0]};

    // FIFO flags from pointer compare; the extra MSB disambiguates full/empty.
    assign tx_count = tx_wp - tx_rp;
    assign rx_count = rx_wp - rx_rp;
    assign tx_empty = (tx_wp == tx_rp);
    assign rx_empty = (rx_wp == rx_rp);
    assign tx_full  = (tx_count == PW'(DEPTH));
    assign rx_full  = (rx_count == PW'(DEPTH));

    assign m_valid_o = !tx_empty;
    assign m_data_o  = tx_mem[tx_rp[AW-1:0]];
    assign s_ready_o = !rx_full;

    assign wr_idx = wr_addr_i[3:2];
    assign rd_idx = rd_addr_i[3:2];

    // Access decode; all flag checks use pre-edge FIFO state.
    assign ctrl_wr    = wr_en_i && (wr_idx == 2'd3) && wr_byteen_i[0];
    assign tx_flush   = ctrl_wr && wr_data_i[0];
    assign rx_flush   = ctrl_wr && wr_data_i[1];
    assign clr_err    = ctrl_wr && wr_data_i[2];
    assign tx_wr      = wr_en_i && (wr_idx == 2'd0) && (|wr_byteen_i);
    assign tx_push    = tx_wr && !tx_full;
    assign tx_ovf_set = tx_wr && tx_full && !tx_flush;
    assign tx_pop     = m_valid_o && m_ready_i;
    assign rx_rd      = rd_en_i && (rd_idx == 2'd1);
    assign rx_pop     = rx_rd && !rx_empty;
    assign rx_udf_set = rx_rd && rx_empty;
    assign rx_push    = s_valid_i && s_ready_o;

    // Disabled byte lanes are stored as zero.
    always_comb begin
        wdata_masked = '0;
        for (int unsigned b = 0; b < BW; b++) begin
            if (wr_byteen_i[b]) begin
                wdata_masked[b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
        end
    end

    // Next pointer/flag state; flush overrides same-edge push/pop.
    always_comb begin
        tx_wp_n = tx_wp;
        tx_rp_n = tx_rp;
        rx_wp_n = rx_wp;
        rx_rp_n = rx_rp;
        if (tx_push) tx_wp_n = tx_wp + PW'(1);
        if (tx_pop)  tx_rp_n = tx_rp + PW'(1);
        if (rx_push) rx_wp_n = rx_wp + PW'(1);
        if (rx_pop)  rx_rp_n = rx_rp + PW'(1);
        if (tx_flush) begin
            tx_wp_n = tx_wp;
            tx_rp_n = tx_wp;
        end
        if (rx_flush) begin
            rx_wp_n = rx_wp;
            rx_rp_n = rx_wp;
        end
        // A same-edge error event beats clr_err.
        tx_ovf_n    = (tx_ovf && !clr_err) || tx_ovf_set;
        rx_udf_n    = (rx_udf && !clr_err) || rx_udf_set;
        rx_irq_en_n = ctrl_wr ? wr_data_i[3] : rx_irq_en;
    end

    // STATUS word.
    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = tx_ovf;
        status[5]     = rx_udf;
        status[15:8]  = 8'(tx_count);
        status[23:16] = 8'(rx_count);
    end

    // Read data select; flush bits always read back 0.
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            2'd1: if (!rx_empty) rd_mux = rx_mem[rx_rp[AW-1:0]];
            2'd2: rd_mux = status;
            2'd3: rd_mux[3] = rx_irq_en;
            default: rd_mux = '0;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wp     <= '0;
            tx_rp     <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            rx_irq_en <= 1'b0;
            rd_data_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            tx_wp     <= tx_wp_n;
            tx_rp     <= tx_rp_n;
            rx_wp     <= rx_wp_n;
            rx_rp     <= rx_rp_n;
            tx_ovf    <= tx_ovf_n;
            rx_udf    <= rx_udf_n;
            rx_irq_en <= rx_irq_en_n;
            if (rd_en_i) rd_data_o <= rd_mux;
            irq_o     <= rx_irq_en_n && (rx_wp_n != rx_rp_n);
        end
    end

    // FIFO storage, not reset.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata_masked;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= s_data_i;
    end

endmodule

// File: tb/tb_mmio_stream_bridge.sv
// Testbench for mmio_stream_bridge: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_mmio_stream_bridge;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteen;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        irq;

    mmio_stream_bridge #(.A_WIDTH(32), .D_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_byteen_i (wr_byteen),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] tq[$];
    logic [31:0] rq[$];
    bit          mdl_ovf, mdl_udf, mdl_irq_en;
    logic [31:0] exp_rd;
    logic        exp_irq;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tq.delete();
        rq.delete();
        mdl_ovf = 0;
        mdl_udf = 0;
        mdl_irq_en = 0;
        exp_rd = 32'h0;
        exp_irq = 1'b0;
    endtask

    task automatic idle_inputs();
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_byteen = 0;
        rd_en = 0; rd_addr = 0; m_ready = 0; s_data = 0; s_valid = 0;
    endtask

    // Called at a falling edge with inputs already applied: checks stream
    // outputs, advances the model across one rising edge, checks registered outputs.
    task automatic do_cycle();
        logic [31:0] st, mw;
        bit tfull, tempty, rfull, rempty, ctrl, tfl, rfl, clr, tset, rset;
        chk("m_valid", 32'(m_valid), 32'(tq.size() != 0));
        if (tq.size() != 0) chk("m_data", m_data, tq[0]);
        chk("s_ready", 32'(s_ready), 32'(rq.size() != DEPTH));
        if (rst) begin
            model_reset();
        end else begin
            tfull  = (tq.size() == DEPTH);
            tempty = (tq.size() == 0);
            rfull  = (rq.size() == DEPTH);
            rempty = (rq.size() == 0);
            st = {8'h00, 8'(rq.size()), 8'(tq.size()), 2'b00,
                  mdl_udf, mdl_ovf, rempty, rfull, tempty, tfull};
            ctrl = wr_en && (wr_addr[3:2] == 2'd3) && wr_byteen[0];
            tfl  = ctrl && wr_data[0];
            rfl  = ctrl && wr_data[1];
            clr  = ctrl && wr_data[2];
            tset = 0;
            rset = 0;
            if (rd_en) begin
                case (rd_addr[3:2])
                    2'd0: exp_rd = 32'h0;
                    2'd1: begin
                        if (rempty) begin
                            exp_rd = 32'h0;
                            rset = 1;
                        end else begin
                            exp_rd = rq.pop_front();
                        end
                    end
                    2'd2: exp_rd = st;
                    default: exp_rd = {28'h0, mdl_irq_en, 3'b000};
                endcase
            end
            if (m_ready && !tempty) void'(tq.pop_front());
            if (wr_en && (wr_addr[3:2] == 2'd0) && (wr_byteen != 4'h0)) begin
                if (tfull) begin
                    tset = !tfl;
                end else begin
                    mw = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (wr_byteen[b]) mw[b*8 +: 8] = wr_data[b*8 +: 8];
                    tq.push_back(mw);
                end
            end
            if (s_valid && !rfull) rq.push_back(s_data);
            if (tfl) tq.delete();
            if (rfl) rq.delete();
            mdl_ovf = (mdl_ovf && !clr) || tset;
            mdl_udf = (mdl_udf && !clr) || rset;
            if (ctrl) mdl_irq_en = wr_data[3];
            exp_irq = mdl_irq_en && (rq.size() != 0);
        end
        @(posedge clk);
        #1;
        chk("rd_data", rd_data, exp_rd);
        chk("irq", 32'(irq), 32'(exp_irq));
        @(negedge clk);
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1; wr_addr = a; wr_data = d; wr_byteen = be;
        do_cycle();
        wr_en = 0; wr_byteen = 0;
    endtask

    task automatic reg_rd(input logic [31:0] a);
        rd_en = 1; rd_addr = a;
        do_cycle();
        rd_en = 0;
    endtask

    initial begin
        int r;
        logic [31:0] a;

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Reset state.
        reg_rd(32'h8);
        chk("reset_status", rd_data, 32'h0000_000A);
        chk("reset_m_valid", 32'(m_valid), 32'h0);
        chk("reset_s_ready", 32'(s_ready), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);

        // Three TX words then drain.
        reg_wr(32'h0, 32'h11, 4'hF);
        reg_wr(32'h0, 32'h22, 4'hF);
        reg_wr(32'h0, 32'h33, 4'hF);
        m_ready = 1;
        chk("tx_seq0", m_data, 32'h11); do_cycle();
        chk("tx_seq1", m_data, 32'h22); do_cycle();
        chk("tx_seq2", m_data, 32'h33); do_cycle();
        chk("tx_seq_empty", 32'(m_valid), 32'h0);
        m_ready = 0;

        // Byte-lane masking.
        reg_wr(32'h0, 32'hDEAD_BEEF, 4'b0101);
        chk("byte_mask", m_data, 32'h00AD_00EF);
        reg_wr(32'h0, 32'h1234_5678, 4'h0);
        m_ready = 1; do_cycle(); m_ready = 0;
        chk("byteen0_nop", 32'(m_valid), 32'h0);

        // Overflow with 17 writes.
        for (int i = 1; i <= 17; i++) reg_wr(32'h0, 32'(i), 4'hF);
        reg_rd(32'h8);
        chk("ovf_tx_count", 32'(rd_data[15:8]), 32'd16);
        chk("ovf_tx_full", 32'(rd_data[0]), 32'h1);
        chk("ovf_flag", 32'(rd_data[4]), 32'h1);
        reg_wr(32'hC, 32'h4, 4'h1);
        reg_rd(32'h8);
        chk("ovf_cleared", 32'(rd_data[4]), 32'h0);
        m_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_drain", m_data, 32'(i));
            do_cycle();
        end
        chk("ovf_word17_absent", 32'(m_valid), 32'h0);
        m_ready = 0;

        // RX interrupt.
        reg_wr(32'hC, 32'h8, 4'h1);
        s_valid = 1; s_data = 32'hA5A5_0001;
        do_cycle();
        s_valid = 0;
        chk("irq_high", 32'(irq), 32'h1);
        reg_rd(32'h4);
        chk("rx_read", rd_data, 32'hA5A5_0001);
        chk("irq_low", 32'(irq), 32'h0);

        // RX full, pop under back-pressure, underflow.
        s_valid = 1;
        for (int i = 0; i < 16; i++) begin
            s_data = $urandom;
            do_cycle();
        end
        chk("rx_full_ready", 32'(s_ready), 32'h0);
        s_data = 32'hCAFE_0017;
        rd_en = 1; rd_addr = 32'h4;
        do_cycle();
        rd_en = 0;
        chk("rx_slot_freed", 32'(s_ready), 32'h1);
        do_cycle();
        s_valid = 0;
        chk("rx_refull", 32'(s_ready), 32'h0);
        for (int i = 0; i < 16; i++) reg_rd(32'h4);
        reg_rd(32'h4);
        chk("rx_udf_data", rd_data, 32'h0);
        reg_rd(32'h8);
        chk("rx_udf_flag", 32'(rd_data[5]), 32'h1);
        reg_wr(32'hC, 32'h4, 4'h1);

        // Flush with same-edge handshake.
        for (int i = 0; i < 5; i++) reg_wr(32'h0, 32'h100 + 32'(i), 4'hF);
        m_ready = 1;
        reg_wr(32'hC, 32'h1, 4'h1);
        m_ready = 0;
        chk("flush_m_valid", 32'(m_valid), 32'h0);
        reg_rd(32'h8);
        chk("flush_tx_count", 32'(rd_data[15:8]), 32'h0);
        chk("flush_tx_ovf", 32'(rd_data[4]), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            wr_en = $urandom_range(0, 1);
            a = $urandom;
            r = $urandom_range(0, 9);
            a[3:2] = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
            wr_addr = a;
            wr_data = $urandom;
            if ($urandom_range(0, 7) != 0) wr_data[1:0] = 2'b00;
            wr_byteen = 4'($urandom_range(0, 15));
            rd_en = $urandom_range(0, 1);
            a = $urandom;
            r = $urandom_range(0, 9);
            a[3:2] = (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
            rd_addr = a;
            m_ready = ($urandom_range(0, 9) < 4);
            s_valid = ($urandom_range(0, 9) < 5);
            s_data = $urandom;
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
